// File: rtl/br_pkg.sv
// -----------------------------------------------------------------------------
// br_pkg
// Shared definitions for the branch controller: FSM state encoding, RISC-V
// B-type funct3 codes and the opcode set understood by the external
// comparison unit.
// -----------------------------------------------------------------------------
package br_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_OPS = 2'd1,
        ST_RESOLVE  = 2'd2,
        ST_FLUSH    = 2'd3
    } br_state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        BR_OP_EQ      = 4'd0,
        BR_OP_NEQ     = 4'd1,
        BR_OP_ULT     = 4'd2,
        BR_OP_SLT     = 4'd3,
        BR_OP_UGE     = 4'd4,
        BR_OP_SGE     = 4'd5,
        BR_OP_ILLEGAL = 4'hF
    } br_op_e;

    function automatic logic br_op_is_legal(br_op_e op);
        return (op != BR_OP_ILLEGAL);
    endfunction

endpackage

// File: rtl/br_funct_decode.sv
// -----------------------------------------------------------------------------
// br_funct_decode
// Combinational translation of a B-type funct3 into the comparison-unit opcode.
//   funct3_i  : B-type funct3 field
//   opcode_o  : comparison opcode (BR_OP_ILLEGAL for 010/011)
//   illegal_o : 1 when funct3 does not encode a branch
// -----------------------------------------------------------------------------
module br_funct_decode
    import br_pkg::*;
(
    input  logic [2:0] funct3_i,
    output br_op_e     opcode_o,
    output logic       illegal_o
);

    always_comb begin
        opcode_o = BR_OP_ILLEGAL;
        case (funct3_i)
            F3_BEQ:  opcode_o = BR_OP_EQ;
            F3_BNE:  opcode_o = BR_OP_NEQ;
            F3_BLT:  opcode_o = BR_OP_SLT;
            F3_BGE:  opcode_o = BR_OP_SGE;
            F3_BLTU: opcode_o = BR_OP_ULT;
            F3_BGEU: opcode_o = BR_OP_UGE;
            default: opcode_o = BR_OP_ILLEGAL;
        endcase
    end

    assign illegal_o = !br_op_is_legal(opcode_o);

endmodule

// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
// EX-stage branch sequencer. Accepts one B-type branch at a time, waits for
// forwarded operands, drives a registered request to the external comparison
// unit, samples its taken result for one cycle, and on a taken branch issues a
// redirect pulse followed by a fixed-length pipeline flush. Keeps saturating
// counts of resolved and taken branches.
//
// Ports
//   clk_i, rst_n_i                 : clock, async active-low reset
//   br_valid_i / br_ready_o        : branch handshake (ready only in IDLE)
//   br_funct3_i, br_pc_i, br_imm_i : branch fields, latched at acceptance
//   ops_ready_i, op_a_i, op_b_i    : forwarded operands
//   bu_op_a_o, bu_op_b_o, bu_opcode_o : registered comparison-unit request
//   bu_branch_i                    : comparison-unit taken result
//   stall_o, flush_o, redirect_o, illegal_o : pipeline control
//   redirect_pc_o                  : branch target (pc + imm)
//   cnt_clr_i, taken_cnt_o, total_cnt_o : statistics
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a branch, pipeline runs freely
// WAIT_OPS | branch latched, stalling until forwarded operands are valid
// RESOLVE  | one cycle: comparison unit result sampled
// FLUSH    | taken branch: flush held for FLUSH_CYCLES cycles
// -----------------------------------------------------------------------------
module branch_ctrl
    import br_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              br_valid_i,
    output logic              br_ready_o,
    input  logic [2:0]        br_funct3_i,
    input  logic [31:0]       br_pc_i,
    input  logic [31:0]       br_imm_i,
    input  logic              ops_ready_i,
    input  logic [31:0]       op_a_i,
    input  logic [31:0]       op_b_i,
    output logic [31:0]       bu_op_a_o,
    output logic [31:0]       bu_op_b_o,
    output logic [3:0]        bu_opcode_o,
    input  logic              bu_branch_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic              redirect_o,
    output logic              illegal_o,
    output logic [31:0]       redirect_pc_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  taken_cnt_o,
    output logic [CNT_W-1:0]  total_cnt_o
);

    localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    br_state_e        state_q;
    logic [3:0]       flush_cnt_q;
    logic [31:0]      pc_q;
    logic [31:0]      imm_q;
    logic [31:0]      op_a_q;
    logic [31:0]      op_b_q;
    br_op_e           opcode_q;
    logic             legal_q;
    logic             ready_q;
    logic             stall_q;
    logic             flush_q;
    logic             redirect_q;
    logic             illegal_q;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] total_cnt_q, total_cnt_d;

    br_op_e dec_opcode;
    logic   dec_illegal;
    logic   resolve_fire;
    logic   taken_fire;

    br_funct_decode u_decode (
        .funct3_i  (br_funct3_i),
        .opcode_o  (dec_opcode),
        .illegal_o (dec_illegal)
    );

    // Illegal funct3 never counts as taken, whatever the comparison unit says.
    assign resolve_fire = (state_q == ST_RESOLVE);
    assign taken_fire   = resolve_fire && legal_q && bu_branch_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            opcode_q    <= BR_OP_EQ;
            legal_q     <= 1'b0;
            ready_q     <= 1'b1;
            stall_q     <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            redirect_q <= 1'b0;
            illegal_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (br_valid_i) begin
                        pc_q     <= br_pc_i;
                        imm_q    <= br_imm_i;
                        opcode_q <= dec_opcode;
                        legal_q  <= !dec_illegal;
                        ready_q  <= 1'b0;
                        stall_q  <= 1'b1;
                        state_q  <= ST_WAIT_OPS;
                    end
                end
                ST_WAIT_OPS: begin
                    if (ops_ready_i) begin
                        op_a_q    <= op_a_i;
                        op_b_q    <= op_b_i;
                        // Raised on entry so the pulse lines up with RESOLVE.
                        illegal_q <= !legal_q;
                        state_q   <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    stall_q <= 1'b0;
                    if (legal_q && bu_branch_i) begin
                        flush_q     <= 1'b1;
                        redirect_q  <= 1'b1;
                        flush_cnt_q <= FLUSH_LOAD;
                        state_q     <= ST_FLUSH;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == 4'd0) begin
                        flush_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
                default: begin
                    stall_q <= 1'b0;
                    flush_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        total_cnt_d = total_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (cnt_clr_i) begin
            total_cnt_d = '0;
            taken_cnt_d = '0;
        end else begin
            if (resolve_fire && total_cnt_q != CNT_MAX) begin
                total_cnt_d = total_cnt_q + CNT_W'(1);
            end
            if (taken_fire && taken_cnt_q != CNT_MAX) begin
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            total_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else begin
            total_cnt_q <= total_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br_ready_o    = ready_q;
    assign stall_o       = stall_q;
    assign flush_o       = flush_q;
    assign redirect_o    = redirect_q;
    assign illegal_o     = illegal_q;
    assign bu_op_a_o     = op_a_q;
    assign bu_op_b_o     = op_b_q;
    assign bu_opcode_o   = opcode_q;
    assign redirect_pc_o = pc_q + imm_q;
    assign taken_cnt_o   = taken_cnt_q;
    assign total_cnt_o   = total_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_ctrl
// Transaction-level bench for branch_ctrl: each branch is driven through its
// whole life and every cycle's control outputs are compared against the
// expected timeline derived from RISC-V branch semantics.
// -----------------------------------------------------------------------------
module tb_branch_ctrl;

    localparam int FC    = 2;
    localparam int CW    = 2;
    localparam int C_MAX = 3;

    logic          clk;
    logic          rst_n;
    logic          br_valid;
    logic          br_ready;
    logic [2:0]    br_funct3;
    logic [31:0]   br_pc;
    logic [31:0]   br_imm;
    logic          ops_ready;
    logic [31:0]   op_a;
    logic [31:0]   op_b;
    logic [31:0]   bu_op_a;
    logic [31:0]   bu_op_b;
    logic [3:0]    bu_opcode;
    logic          bu_branch;
    logic          stall;
    logic          flush;
    logic          redirect;
    logic          illegal;
    logic [31:0]   redirect_pc;
    logic          cnt_clr;
    logic [CW-1:0] taken_cnt;
    logic [CW-1:0] total_cnt;

    logic          force_br;
    logic          cmp_res;

    int n_tests = 0;
    int n_fail  = 0;
    int m_taken = 0;
    int m_total = 0;

    branch_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .br_valid_i    (br_valid),
        .br_ready_o    (br_ready),
        .br_funct3_i   (br_funct3),
        .br_pc_i       (br_pc),
        .br_imm_i      (br_imm),
        .ops_ready_i   (ops_ready),
        .op_a_i        (op_a),
        .op_b_i        (op_b),
        .bu_op_a_o     (bu_op_a),
        .bu_op_b_o     (bu_op_b),
        .bu_opcode_o   (bu_opcode),
        .bu_branch_i   (bu_branch),
        .stall_o       (stall),
        .flush_o       (flush),
        .redirect_o    (redirect),
        .illegal_o     (illegal),
        .redirect_pc_o (redirect_pc),
        .cnt_clr_i     (cnt_clr),
        .taken_cnt_o   (taken_cnt),
        .total_cnt_o   (total_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External comparison unit, as it would sit at CPU top level.
    always_comb begin
        cmp_res = 1'b0;
        case (bu_opcode)
            4'd0: cmp_res = (bu_op_a == bu_op_b);
            4'd1: cmp_res = (bu_op_a != bu_op_b);
            4'd2: cmp_res = (bu_op_a < bu_op_b);
            4'd3: cmp_res = ($signed(bu_op_a) < $signed(bu_op_b));
            4'd4: cmp_res = (bu_op_a >= bu_op_b);
            4'd5: cmp_res = ($signed(bu_op_a) >= $signed(bu_op_b));
            default: cmp_res = 1'b0;
        endcase
        bu_branch = cmp_res | force_br;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // {ready, stall, flush, redirect, illegal}
    function automatic logic [4:0] stat();
        return {br_ready, stall, flush, redirect, illegal};
    endfunction

    function automatic bit ref_legal(input logic [2:0] f3);
        return !(f3 == 3'b010 || f3 == 3'b011);
    endfunction

    function automatic bit ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return 4'd0;
            3'b001:  return 4'd1;
            3'b100:  return 4'd3;
            3'b101:  return 4'd5;
            3'b110:  return 4'd2;
            3'b111:  return 4'd4;
            default: return 4'hF;
        endcase
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= C_MAX) ? C_MAX : v + 1;
    endfunction

    // Drives one branch from acceptance to its return to IDLE. rst_at >= 0
    // pulls reset during that FLUSH cycle (0-based) and returns mid-cycle,
    // with reset already released, so the next call accepts on the next edge.
    task automatic do_branch(input logic [2:0] f3, input logic [31:0] pc,
                             input logic [31:0] imm, input logic [31:0] a,
                             input logic [31:0] b, input int nwait,
                             input bit clr, input bit frc, input int rst_at);
        bit leg;
        bit taken;
        leg   = ref_legal(f3);
        taken = leg && (ref_cond(f3, a, b) || frc);

        check("idle_stat", 32'(stat()), 32'h10);
        br_valid  = 1'b1;
        br_funct3 = f3;
        br_pc     = pc;
        br_imm    = imm;
        ops_ready = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        @(negedge clk);

        for (int k = 0; k < nwait; k++) begin
            check("wait_stat", 32'(stat()), 32'h08);
            br_valid  = 1'($urandom_range(0, 1));
            br_funct3 = 3'($urandom);
            br_pc     = $urandom;
            br_imm    = $urandom;
            if (k == nwait - 1) begin
                ops_ready = 1'b1;
                op_a      = a;
                op_b      = b;
            end else begin
                ops_ready = 1'b0;
                op_a      = $urandom;
                op_b      = $urandom;
            end
            @(negedge clk);
        end

        check("res_stat", 32'(stat()), {27'd0, 4'b0100, !leg});
        check("res_opcode", 32'(bu_opcode), 32'(ref_op(f3)));
        check("res_op_a", bu_op_a, a);
        check("res_op_b", bu_op_b, b);
        ops_ready = 1'($urandom_range(0, 1));
        op_a      = $urandom;
        op_b      = $urandom;
        br_valid  = 1'($urandom_range(0, 1));
        force_br  = frc;
        cnt_clr   = clr;
        if (clr) begin
            m_total = 0;
            m_taken = 0;
        end else begin
            m_total = sat_inc(m_total);
            if (taken) m_taken = sat_inc(m_taken);
        end
        @(negedge clk);
        force_br = 1'b0;
        cnt_clr  = 1'b0;
        br_valid = 1'b0;
        check("total_cnt", 32'(total_cnt), 32'(m_total));
        check("taken_cnt", 32'(taken_cnt), 32'(m_taken));

        if (taken) begin
            for (int i = 0; i < FC; i++) begin
                check("flush_stat", 32'(stat()), {27'd0, 3'b001, (i == 0), 1'b0});
                check("redirect_pc", redirect_pc, pc + imm);
                if (i == rst_at) begin
                    rst_n    = 1'b0;
                    br_valid = 1'b0;
                    #1;
                    check("rst_stat", 32'(stat()), 32'h10);
                    check("rst_total", 32'(total_cnt), 32'd0);
                    check("rst_taken", 32'(taken_cnt), 32'd0);
                    check("rst_pc", redirect_pc, 32'd0);
                    check("rst_op_a", bu_op_a, 32'd0);
                    m_total = 0;
                    m_taken = 0;
                    #1;
                    rst_n = 1'b1;
                    return;
                end
                br_valid  = 1'($urandom_range(0, 1));
                br_funct3 = 3'($urandom);
                @(negedge clk);
            end
            br_valid = 1'b0;
        end
        check("done_stat", 32'(stat()), 32'h10);
    endtask

    task automatic idle_clear();
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        m_total = 0;
        m_taken = 0;
        check("clr_total", 32'(total_cnt), 32'd0);
        check("clr_taken", 32'(taken_cnt), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        br_valid  = 1'b0;
        br_funct3 = '0;
        br_pc     = '0;
        br_imm    = '0;
        ops_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        cnt_clr   = 1'b0;
        force_br  = 1'b0;

        #12;
        check("reset_stat", 32'(stat()), 32'h10);
        check("reset_total", 32'(total_cnt), 32'd0);
        check("reset_taken", 32'(taken_cnt), 32'd0);
        check("reset_opcode", 32'(bu_opcode), 32'd0);
        check("reset_pc", redirect_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // BEQ taken, minimum latency
        do_branch(3'b000, 32'h100, 32'h20, 32'h5, 32'h5, 1, 1'b0, 1'b0, -1);
        // BLT taken after operands arrive late
        do_branch(3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 3, 1'b0, 1'b0, -1);
        // BGEU not taken from a cleared count
        idle_clear();
        do_branch(3'b111, 32'h300, 32'h8, 32'h1, 32'h2, 1, 1'b0, 1'b0, -1);
        // illegal funct3 with the comparison unit forced taken
        do_branch(3'b010, 32'h400, 32'h10, 32'h7, 32'h7, 1, 1'b0, 1'b1, -1);
        // BNE target wrap-around
        do_branch(3'b001, 32'hFFFF_FFF0, 32'h20, 32'h3, 32'h4, 2, 1'b0, 1'b0, -1);
        // reset in the second flush cycle, then immediate acceptance
        do_branch(3'b000, 32'h500, 32'h4, 32'h9, 32'h9, 1, 1'b0, 1'b0, 1);
        do_branch(3'b101, 32'h600, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, -1);
        // saturation after four taken branches, then clear on RESOLVE
        idle_clear();
        for (int i = 0; i < 4; i++)
            do_branch(3'b000, 32'h700, 32'h10, 32'hA, 32'hA, 1, 1'b0, 1'b0, -1);
        check("sat_taken", 32'(taken_cnt), 32'd3);
        do_branch(3'b000, 32'h700, 32'h10, 32'hA, 32'hA, 1, 1'b1, 1'b0, -1);
        check("clr_on_resolve", 32'(taken_cnt), 32'd0);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            do_branch(3'($urandom_range(0, 7)), $urandom, $urandom, ra, rb,
                      $urandom_range(1, 4), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 5) == 0), -1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
